// File: rtl/bus_pkg.sv
// Shared definitions for the 16-bit peripheral bus: master FSM states, bus widths
// and register offsets of known slaves.
package bus_pkg;

    localparam int BUS_DATA_W          = 16;
    localparam int BUS_ADDR_W          = 8;
    localparam int BUS_TIMEOUT_DEFAULT = 255;

    // Interrupt controller register map
    localparam logic [7:0] INTCTRL_CTRL = 8'h02;
    localparam logic [7:0] INTCTRL_EN   = 8'h06;
    localparam logic [7:0] INTCTRL_STAT = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        BUS  = 2'd2,
        RESP = 2'd3
    } bus_state_e;

endpackage

// File: rtl/bus_watchdog.sv
// Loadable up-counter with clear and enable; expire_o flags that the count has
// reached LIMIT-1. Used by bus_master to abort unacknowledged transactions.
module bus_watchdog
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        en_i,
    output logic        expire_o
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == LAST);

endmodule

// File: rtl/bus_master.sv
// bus_master: single-transaction initiator for the 16-bit peripheral bus.
// Define BUS_MASTER_TIMEOUT_EN to add the ack watchdog and timeout error responses.
module bus_master
    import bus_pkg::*;
#(
    parameter int ADDR_W         = BUS_ADDR_W,
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [BUS_DATA_W-1:0] cmd_wdata,
    input  logic                  cmd_uds,
    input  logic                  cmd_lds,
    output logic                  rsp_valid,
    output logic [BUS_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     addr,
    output logic [BUS_DATA_W-1:0] data_write,
    input  logic [BUS_DATA_W-1:0] data_read,
    output logic                  uds,
    output logic                  lds,
    output logic                  rw,
    output logic                  as,
    input  logic                  ack
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("bus_master: TIMEOUT_CYCLES must lie in 2..65535");
    end

    bus_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BUS_DATA_W-1:0] data_write_q, data_write_d;
    logic [BUS_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  uds_q, uds_d;
    logic                  lds_q, lds_d;
    logic                  rw_q, rw_d;
    logic                  as_q, as_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  timeout_hit;

`ifdef BUS_MASTER_TIMEOUT_EN
    // Counter is held at zero in IDLE and counts every ARM and BUS cycle.
    bus_watchdog #(
        .LIMIT      (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state_q == IDLE),
        .load_i     (1'b0),
        .load_val_i (16'd0),
        .en_i       ((state_q == ARM) || (state_q == BUS)),
        .expire_o   (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        rsp_rdata_d  = rsp_rdata_q;
        uds_d        = uds_q;
        lds_d        = lds_q;
        rw_d         = rw_q;
        as_d         = as_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d       = cmd_addr;
                    data_write_d = cmd_wdata;
                    rw_d         = cmd_rw;
                    uds_d        = cmd_uds;
                    lds_d        = cmd_lds;
                    as_d         = 1'b1;
                    state_d      = ARM;
                end
            end
            // ack may still be asserted from the previous address here, so it is not looked at.
            ARM: state_d = BUS;
            BUS: begin
                if (ack || timeout_hit) begin
                    rsp_err_d   = ~ack;
                    rsp_rdata_d = (ack && rw_q) ? data_read : '0;
                    as_d        = 1'b0;
                    uds_d       = 1'b0;
                    lds_d       = 1'b0;
                    rw_d        = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_write_q <= '0;
            rsp_rdata_q  <= '0;
            uds_q        <= 1'b0;
            lds_q        <= 1'b0;
            rw_q         <= 1'b1;
            as_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            rsp_rdata_q  <= rsp_rdata_d;
            uds_q        <= uds_d;
            lds_q        <= lds_d;
            rw_q         <= rw_d;
            as_q         <= as_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign addr       = addr_q;
    assign data_write = data_write_q;
    assign uds        = uds_q;
    assign lds        = lds_q;
    assign rw         = rw_q;
    assign as         = as_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed self-checking bench for bus_master against a small interrupt-controller
// slave model whose ack lingers a few cycles after the address strobe drops.
module tb_bus_master;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_rw, cmd_uds, cmd_lds;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [7:0]  addr;
    logic [15:0] data_write, data_read;
    logic        uds, lds, rw, as, ack;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_count = 0;

    always #5 clk = ~clk;

    bus_master #(
        .ADDR_W         (8),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rw     (cmd_rw),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_uds    (cmd_uds),
        .cmd_lds    (cmd_lds),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .addr       (addr),
        .data_write (data_write),
        .data_read  (data_read),
        .uds        (uds),
        .lds        (lds),
        .rw         (rw),
        .as         (as),
        .ack        (ack)
    );

    // Slave model: registered ack/data, ack held 3 extra cycles after as drops.
    logic [15:0] reg_ctrl, reg_en;
    int          hold;
    localparam logic [15:0] STAT_VAL = 16'h00A5;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic u, input logic l);
        return {u ? wd[15:8] : old[15:8], l ? wd[7:0] : old[7:0]};
    endfunction

    function automatic logic [15:0] slave_rd(input logic [7:0] a, input logic u, input logic l);
        logic [15:0] v;
        case (a)
            INTCTRL_CTRL: v = reg_ctrl;
            INTCTRL_EN:   v = reg_en;
            default:      v = STAT_VAL;
        endcase
        return {u ? v[15:8] : 8'h00, l ? v[7:0] : 8'h00};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ack       <= 1'b0;
            data_read <= 16'h0000;
            hold      <= 0;
            reg_ctrl  <= 16'h0000;
            reg_en    <= 16'h0000;
        end else if (as && (addr == INTCTRL_CTRL || addr == INTCTRL_EN || addr == INTCTRL_STAT)) begin
            ack       <= 1'b1;
            hold      <= 3;
            data_read <= slave_rd(addr, uds, lds);
            if (!rw && addr == INTCTRL_CTRL) reg_ctrl <= merge(reg_ctrl, data_write, uds, lds);
            if (!rw && addr == INTCTRL_EN)   reg_en   <= merge(reg_en, data_write, uds, lds);
        end else if (hold > 0) begin
            hold <= hold - 1;
            ack  <= 1'b1;
        end else begin
            ack <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rsp_valid) rsp_count++;
    endtask

    task automatic issue(input logic r, input logic [7:0] a, input logic [15:0] wd,
                         input logic u, input logic l);
        int g;
        g = 0;
        while (!cmd_ready && g < 50) begin
            tick();
            g++;
        end
        check("issue_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_rw    = r;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_uds   = u;
        cmd_lds   = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("rsp_seen", rsp_valid, 1'b1);
    endtask

    task automatic check_released(input string tag);
        check({tag, "_as"}, as, 1'b0);
        check({tag, "_rw"}, rw, 1'b1);
        check({tag, "_strobes"}, {uds, lds}, 2'b00);
    endtask

    task automatic reset_mid();
        int n0;
        #3 reset = 1'b1;
        #1;
        check_released("rst_async");
        check("rst_addr", addr, 8'h00);
        check("rst_wdata", data_write, 16'h0000);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 18'h0);
        n0 = rsp_count;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("rst_no_rsp", rsp_count, n0);
        check("rst_ready_after", cmd_ready, 1'b1);
    endtask

    typedef struct packed {
        logic        rw;
        logic [7:0]  a;
        logic [15:0] wd;
        logic        u;
        logic        l;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int g;
        int n0;

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_rw = 1'b1; cmd_addr = 8'h00; cmd_wdata = 16'h0000;
        cmd_uds = 1'b0; cmd_lds = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_released("reset");
        check("reset_addr", addr, 8'h00);
        check("reset_wdata", data_write, 16'h0000);
        check("reset_ready", cmd_ready, 1'b1);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 18'h0);
        reset = 1'b0;
        repeat (2) tick();

        // Write ctrl global enable
        issue(1'b0, INTCTRL_CTRL, 16'h0001, 1'b0, 1'b1);
        check("wr_as", as, 1'b1);
        check("wr_rw", rw, 1'b0);
        check("wr_addr", addr, 8'h02);
        check("wr_data", data_write, 16'h0001);
        check("wr_strobes", {uds, lds}, 2'b01);
        check("wr_busy", cmd_ready, 1'b0);
        wait_rsp(lat);
        check("wr_latency", lat, 2);
        check("wr_err", rsp_err, 1'b0);
        check("wr_rdata", rsp_rdata, 16'h0000);
        check_released("wr_resp");
        tick();
        check("wr_pulse_end", rsp_valid, 1'b0);
        check("wr_ready_again", cmd_ready, 1'b1);
        check("wr_global_en", reg_ctrl[0], 1'b1);

        // Write then read the enable register
        issue(1'b0, INTCTRL_EN, 16'h0003, 1'b0, 1'b1);
        wait_rsp(lat);
        issue(1'b1, INTCTRL_EN, 16'h0000, 1'b0, 1'b1);
        wait_rsp(lat);
        check("rd_en_latency", lat, 2);
        check("rd_en_data", rsp_rdata, 16'h0003);

        // No byte strobes: still acked, data comes back empty
        issue(1'b1, INTCTRL_EN, 16'h0000, 1'b0, 1'b0);
        wait_rsp(lat);
        check("nostrobe_data", rsp_rdata, 16'h0000);
        check("nostrobe_err", rsp_err, 1'b0);

        // Back-to-back reads; the second ARM sees a stale ack carrying status data
        issue(1'b1, INTCTRL_STAT, 16'h0000, 1'b1, 1'b1);
        wait_rsp(lat);
        check("b2b_stat", rsp_rdata, 16'h00A5);
        issue(1'b1, INTCTRL_CTRL, 16'h0000, 1'b1, 1'b1);
        wait_rsp(lat);
        check("b2b_ctrl", rsp_rdata, 16'h0001);
        check("b2b_latency", lat, 2);

        repeat (6) tick();

        // Unmapped address
        issue(1'b1, 8'hF0, 16'h0000, 1'b1, 1'b1);
`ifdef BUS_MASTER_TIMEOUT_EN
        wait_rsp(lat);
        check("to_latency", lat, 8);
        check("to_err", rsp_err, 1'b1);
        check("to_rdata", rsp_rdata, 16'h0000);
        check_released("to_resp");
        tick();
        check("to_as_after", as, 1'b0);
        check("to_ready", cmd_ready, 1'b1);
        repeat (2) tick();
`else
        n0 = rsp_count;
        repeat (20) tick();
        check("wait_no_rsp", rsp_count, n0);
        check("wait_as_held", as, 1'b1);
        check("wait_busy", cmd_ready, 1'b0);
        reset_mid();
`endif

        // Reset during BUS
        issue(1'b1, 8'hF0, 16'h0000, 1'b1, 1'b1);
        repeat (3) tick();
        check("pre_rst_as", as, 1'b1);
        reset_mid();
        issue(1'b0, INTCTRL_CTRL, 16'h12FF, 1'b0, 1'b1);
        wait_rsp(lat);
        check("post_rst_wr_latency", lat, 2);
        issue(1'b1, INTCTRL_CTRL, 16'h0000, 1'b1, 1'b1);
        wait_rsp(lat);
        check("post_rst_rd", rsp_rdata, 16'h00FF);
        check("post_rst_err", rsp_err, 1'b0);

        // cmd_valid held high; fields scrambled while busy must be ignored
        vecs[0] = '{1'b0, INTCTRL_EN,   16'h1234, 1'b1, 1'b1, 16'h0000};
        vecs[1] = '{1'b1, INTCTRL_EN,   16'h0000, 1'b1, 1'b1, 16'h1234};
        vecs[2] = '{1'b0, INTCTRL_EN,   16'hABCD, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, INTCTRL_EN,   16'h0000, 1'b0, 1'b1, 16'h0034};
        vecs[4] = '{1'b1, INTCTRL_STAT, 16'h0000, 1'b1, 1'b1, 16'h00A5};
        vecs[5] = '{1'b1, INTCTRL_CTRL, 16'h0000, 1'b1, 1'b1, 16'h00FF};
        n0 = rsp_count;
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_rw = vecs[i].rw; cmd_addr = vecs[i].a; cmd_wdata = vecs[i].wd;
            cmd_uds = vecs[i].u; cmd_lds = vecs[i].l;
            g = 0;
            while (!cmd_ready && g < 20) begin
                tick();
                g++;
            end
            check("cont_ready", cmd_ready, 1'b1);
            check_released("cont_idle");
            tick();
            check("cont_busy", cmd_ready, 1'b0);
            check("cont_addr", addr, vecs[i].a);
            check("cont_rw", rw, vecs[i].rw);
            cmd_addr = 8'hF0;
            cmd_rw   = ~vecs[i].rw;
            g = 0;
            while (!rsp_valid && g < 20) begin
                tick();
                g++;
                if (!rsp_valid) check("cont_addr_hold", addr, vecs[i].a);
            end
            if (i == 5) cmd_valid = 1'b0;
            check("cont_rsp", rsp_valid, 1'b1);
            check("cont_rdata", rsp_rdata, vecs[i].exp);
            check("cont_err", rsp_err, 1'b0);
            check_released("cont_resp");
        end
        repeat (6) tick();
        check("cont_rsp_count", rsp_count - n0, 6);
        check("cont_final_ready", cmd_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
